// File: rtl/cam_emu_pkg.sv
// Shared types and constants for the camera sensor emulator.
package cam_emu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBP    = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_HBLANK = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        MODE_COUNTER  = 2'd0,
        MODE_RAMP     = 2'd1,
        MODE_BARS     = 2'd2,
        MODE_LINE_TAG = 2'd3
    } mode_t;

    // Colour-bar levels, left to right, as the 8 MSBs of cam_data.
    localparam logic [7:0] BAR_LUT [8] = '{
        8'hFF, 8'hE0, 8'hC0, 8'hA0, 8'h80, 8'h60, 8'h40, 8'h20
    };

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cam_pattern_src.sv
// Next-value generator for cam_data; purely combinational.
module cam_pattern_src
    import cam_emu_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned BPP    = 2,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 7,
    parameter int unsigned LINE_W = 5
) (
    input  logic [1:0]        i_mode,
    input  logic [2:0]        i_state,
    input  logic [CNT_W-1:0]  i_byte_idx,
    input  logic [LINE_W-1:0] i_line_idx,
    input  logic [7:0]        i_frame_lsb,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data_c
);

    localparam int unsigned BAR_PIX = WIDTH / 8;

    logic        w_active;
    logic [31:0] w_pix;
    logic [2:0]  w_bar;

    assign w_active = (i_state == ST_ACTIVE);
    assign w_pix    = 32'(i_byte_idx) / BPP;
    assign w_bar    = 3'(w_pix / BAR_PIX);

    // Select the pattern value for the byte that the FSM is emitting next.
    always_comb begin
        o_data_c = '0;
        case (mode_t'(i_mode))
            MODE_COUNTER:  o_data_c = (i_state == ST_IDLE) ? i_data : i_data + DATA_W'(1);
            MODE_RAMP:     if (w_active) o_data_c = DATA_W'(i_byte_idx);
            MODE_BARS:     if (w_active) o_data_c = DATA_W'(BAR_LUT[w_bar]) << (DATA_W - 8);
            MODE_LINE_TAG: begin
                if (w_active) begin
                    if (i_byte_idx == '0)
                        o_data_c = DATA_W'(i_line_idx);
                    else if (i_byte_idx == CNT_W'(1))
                        o_data_c = DATA_W'(i_frame_lsb);
                    else
                        o_data_c = DATA_W'(i_byte_idx);
                end
            end
            default: o_data_c = '0;
        endcase
    end

endmodule

// File: rtl/cam_pattern_gen.sv
// DVP-style camera emulator: frame timing FSM, counters and registered outputs.
module cam_pattern_gen
    import cam_emu_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned HEIGHT     = 16,
    parameter int unsigned BPP        = 2,
    parameter int unsigned VSYNC_LEN  = 100,
    parameter int unsigned VBP_LEN    = 100,
    parameter int unsigned HBLANK_LEN = 10,
    parameter int unsigned DATA_W     = 8,
    parameter logic        VSYNC_POL  = 1'b1
) (
    input  logic              cam_pclk,
    input  logic              cam_rstn,
    input  logic              enable,
    input  logic [1:0]        mode,
    output logic              cam_vsync,
    output logic              cam_href,
    output logic [DATA_W-1:0] cam_data,
    output logic              frame_done,
    output logic [15:0]       frame_cnt
);

    localparam int unsigned LINE_BYTES = WIDTH * BPP;
    localparam int unsigned CNT_MAX    = max2(max2(VSYNC_LEN, VBP_LEN), max2(LINE_BYTES, HBLANK_LEN));
    localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);
    localparam int unsigned LINE_W     = $clog2(HEIGHT + 1);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [LINE_W-1:0]   r_line;
    mode_t               r_mode;

    logic                r_vsync;
    logic                r_href;
    logic [DATA_W-1:0]   r_data;
    logic                r_frame_done;
    logic [15:0]         r_frame_cnt;

    logic [CNT_W-1:0]    w_last;
    logic                w_phase_end;
    logic                w_last_line;
    logic                w_frame_end;
    logic [DATA_W-1:0]   w_next_data;

    // Terminal count of the phase currently in progress.
    always_comb begin
        w_last = '0;
        case (r_state)
            ST_VSYNC:  w_last = CNT_W'(VSYNC_LEN - 1);
            ST_VBP:    w_last = CNT_W'(VBP_LEN - 1);
            ST_ACTIVE: w_last = CNT_W'(LINE_BYTES - 1);
            ST_HBLANK: w_last = CNT_W'(HBLANK_LEN - 1);
            default:   w_last = '0;
        endcase
    end

    assign w_phase_end = (r_cnt == w_last);
    assign w_last_line = (r_line == LINE_W'(HEIGHT - 1));
    assign w_frame_end = (r_state == ST_HBLANK) && w_phase_end && w_last_line;

    // Frame sequencing: phase counter, line counter and per-frame mode latch.
    always_ff @(posedge cam_pclk or negedge cam_rstn) begin
        if (!cam_rstn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_line  <= '0;
            r_mode  <= MODE_COUNTER;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        r_state <= ST_VSYNC;
                        r_cnt   <= '0;
                        r_line  <= '0;
                        r_mode  <= mode_t'(mode);
                    end
                end
                ST_VSYNC: begin
                    if (w_phase_end) begin
                        r_state <= ST_VBP;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_VBP: begin
                    if (w_phase_end) begin
                        r_state <= ST_ACTIVE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_ACTIVE: begin
                    if (w_phase_end) begin
                        r_state <= ST_HBLANK;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_HBLANK: begin
                    if (w_phase_end) begin
                        r_cnt <= '0;
                        if (w_last_line) begin
                            r_line <= '0;
                            if (enable) begin
                                r_state <= ST_VSYNC;
                                r_mode  <= mode_t'(mode);
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_line  <= r_line + LINE_W'(1);
                            r_state <= ST_ACTIVE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    cam_pattern_src #(
        .WIDTH  (WIDTH),
        .BPP    (BPP),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W),
        .LINE_W (LINE_W)
    ) u_src (
        .i_mode      (r_mode),
        .i_state     (r_state),
        .i_byte_idx  (r_cnt),
        .i_line_idx  (r_line),
        .i_frame_lsb (r_frame_cnt[7:0]),
        .i_data      (r_data),
        .o_data_c    (w_next_data)
    );

    // Output stage: syncs, data and frame bookkeeping follow the FSM by one cycle.
    always_ff @(posedge cam_pclk or negedge cam_rstn) begin
        if (!cam_rstn) begin
            r_vsync      <= ~VSYNC_POL;
            r_href       <= 1'b0;
            r_data       <= '0;
            r_frame_done <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_vsync      <= (r_state == ST_VSYNC) ? VSYNC_POL : ~VSYNC_POL;
            r_href       <= (r_state == ST_ACTIVE);
            r_data       <= w_next_data;
            r_frame_done <= w_frame_end;
            r_frame_cnt  <= r_frame_cnt + 16'(r_frame_done);
        end
    end

    assign cam_vsync  = r_vsync;
    assign cam_href   = r_href;
    assign cam_data   = r_data;
    assign frame_done = r_frame_done;
    assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_cam_pattern_gen.sv
// Scoreboard bench for cam_pattern_gen: two parameterisations share stimulus.
module tb_cam_pattern_gen;

    logic       clk    = 1'b0;
    logic       rstn   = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] mode   = 2'd0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    typedef struct {
        int vs;
        int hr;
        int d;
        int dn;
        int fc;
    } exp_t;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, req, $time);
        end
    endtask

    // Expected outputs from the position p within a frame (0 = first vsync cycle).
    function automatic exp_t ref_out(input int vs_len, input int vbp_len, input int w,
                                     input int h, input int bpp, input int hb,
                                     input int dw, input int pol, input bit busy,
                                     input int p, input int md, input int prev,
                                     input int fc);
        exp_t e;
        int   bars [8];
        int   lb, lp, q, x, ln, mask;
        bars = '{255, 224, 192, 160, 128, 96, 64, 32};
        mask = (1 << dw) - 1;
        lb   = w * bpp;
        lp   = lb + hb;
        e.vs = (busy && p < vs_len) ? pol : 1 - pol;
        e.hr = 0;
        e.dn = 0;
        e.fc = fc;
        x    = 0;
        ln   = 0;
        if (busy) begin
            q = p - vs_len - vbp_len;
            if (q >= 0) begin
                ln   = q / lp;
                x    = q % lp;
                e.hr = (x < lb) ? 1 : 0;
            end
            e.dn = (p == vs_len + vbp_len + h * lp - 1) ? 1 : 0;
        end
        case (md)
            0:       e.d = busy ? ((prev + 1) & mask) : prev;
            1:       e.d = (e.hr != 0) ? (x & mask) : 0;
            2:       e.d = (e.hr != 0) ? ((bars[(x / bpp) / (w / 8)] << (dw - 8)) & mask) : 0;
            default: e.d = (e.hr != 0) ? (((x == 0) ? ln : (x == 1) ? (fc & 255) : x) & mask) : 0;
        endcase
        return e;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int P_W      = (g == 0) ? 32  : 16;
        localparam int P_H      = (g == 0) ? 16  : 6;
        localparam int P_BPP    = (g == 0) ? 2   : 1;
        localparam int P_VS     = (g == 0) ? 100 : 5;
        localparam int P_VBP    = (g == 0) ? 100 : 4;
        localparam int P_HB     = (g == 0) ? 10  : 3;
        localparam int P_DW     = (g == 0) ? 8   : 10;
        localparam int P_POL    = (g == 0) ? 1   : 0;
        localparam int P_PERIOD = P_VS + P_VBP + P_H * (P_W * P_BPP + P_HB);

        logic            w_vsync;
        logic            w_href;
        logic [P_DW-1:0] w_data;
        logic            w_done;
        logic [15:0]     w_fc;

        cam_pattern_gen #(
            .WIDTH      (P_W),
            .HEIGHT     (P_H),
            .BPP        (P_BPP),
            .VSYNC_LEN  (P_VS),
            .VBP_LEN    (P_VBP),
            .HBLANK_LEN (P_HB),
            .DATA_W     (P_DW),
            .VSYNC_POL  (1'(P_POL))
        ) u_dut (
            .cam_pclk   (clk),
            .cam_rstn   (rstn),
            .enable     (enable),
            .mode       (mode),
            .cam_vsync  (w_vsync),
            .cam_href   (w_href),
            .cam_data   (w_data),
            .frame_done (w_done),
            .frame_cnt  (w_fc)
        );

        exp_t q [$];
        bit   m_busy      = 1'b0;
        int   m_p         = 0;
        int   m_mode      = 0;
        int   m_prev      = 0;
        int   m_fc        = 0;
        bit   m_last_done = 1'b0;

        // Reference model: pushes the expected output for every clock edge.
        initial begin : model
            exp_t e;
            forever begin
                @(posedge clk or negedge rstn);
                if (!rstn) begin
                    q.delete();
                    m_busy      = 1'b0;
                    m_p         = 0;
                    m_mode      = 0;
                    m_prev      = 0;
                    m_fc        = 0;
                    m_last_done = 1'b0;
                end else begin
                    if (m_last_done) m_fc = (m_fc + 1) & 16'hFFFF;
                    e = ref_out(P_VS, P_VBP, P_W, P_H, P_BPP, P_HB, P_DW, P_POL,
                                m_busy, m_p, m_mode, m_prev, m_fc);
                    m_prev      = e.d;
                    m_last_done = (e.dn != 0);
                    q.push_back(e);
                    if (!m_busy) begin
                        if (enable) begin
                            m_busy = 1'b1;
                            m_p    = 0;
                            m_mode = int'(mode);
                        end
                    end else if (m_p == P_PERIOD - 1) begin
                        if (enable) begin
                            m_p    = 0;
                            m_mode = int'(mode);
                        end else begin
                            m_busy = 1'b0;
                        end
                    end else begin
                        m_p++;
                    end
                end
            end
        end

        // Monitor: compares DUT outputs just after each edge against the model.
        initial begin : monitor
            exp_t e;
            forever begin
                @(posedge clk);
                #1;
                if (rstn) begin
                    if (q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL i%0d_queue no expected entry t=%0t", g, $time);
                    end else begin
                        e = q.pop_front();
                        chk($sformatf("i%0d_vsync", g), int'(w_vsync), e.vs);
                        chk($sformatf("i%0d_href", g),  int'(w_href),  e.hr);
                        chk($sformatf("i%0d_data", g),  int'(w_data),  e.d);
                        chk($sformatf("i%0d_done", g),  int'(w_done),  e.dn);
                        chk($sformatf("i%0d_fcnt", g),  int'(w_fc),    e.fc);
                    end
                end
            end
        end
    end

    task automatic wait_idle(input int lim);
        int i;
        for (i = 0; i < lim && (g_dut[0].m_busy || g_dut[1].m_busy); i++) @(negedge clk);
        if (g_dut[0].m_busy || g_dut[1].m_busy) begin
            checks++;
            failures++;
            $display("FAIL wait_idle frame did not end within %0d cycles", lim);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic pulse_frame(input int m);
        @(negedge clk);
        mode   = 2'(m);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        wait_idle(2000);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_vsync0"}, int'(g_dut[0].w_vsync), 0);
        chk({tag, "_vsync1"}, int'(g_dut[1].w_vsync), 1);
        chk({tag, "_href0"},  int'(g_dut[0].w_href),  0);
        chk({tag, "_href1"},  int'(g_dut[1].w_href),  0);
        chk({tag, "_data0"},  int'(g_dut[0].w_data),  0);
        chk({tag, "_data1"},  int'(g_dut[1].w_data),  0);
        chk({tag, "_done0"},  int'(g_dut[0].w_done),  0);
        chk({tag, "_fcnt0"},  int'(g_dut[0].w_fc),    0);
        chk({tag, "_fcnt1"},  int'(g_dut[1].w_fc),    0);
    endtask

    initial begin : stimulus
        int n;
        int i;
        repeat (3) @(negedge clk);
        chk_reset_outputs("por");
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        // Single frames in modes 0, 1, 2.
        pulse_frame(0);
        pulse_frame(1);
        pulse_frame(2);
        chk("fcnt_after_single0", int'(g_dut[0].w_fc), 3);
        chk("fcnt_after_single1", int'(g_dut[1].w_fc), 3);

        // Back-to-back frames in mode 3, enable dropped inside the third frame.
        @(negedge clk);
        mode   = 2'd3;
        enable = 1'b1;
        repeat (2 * 1384 + 700) @(negedge clk);
        enable = 1'b0;
        wait_idle(3000);
        chk("fcnt_after_hold0", int'(g_dut[0].w_fc), 6);

        // Random enable windows and mid-frame mode changes.
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            mode   = 2'($urandom_range(0, 3));
            enable = 1'b1;
            n = int'($urandom_range(1, 2000));
            for (i = 0; i < n; i++) begin
                @(negedge clk);
                if ($urandom_range(0, 199) == 0) mode = 2'($urandom_range(0, 3));
            end
            enable = 1'b0;
            repeat ($urandom_range(1, 1600)) @(negedge clk);
        end
        wait_idle(3000);

        // Asynchronous reset in the middle of an active line.
        @(negedge clk);
        mode   = 2'd1;
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        for (i = 0; i < 1500 && !g_dut[0].w_href; i++) @(negedge clk);
        chk("href_seen_before_reset", int'(g_dut[0].w_href), 1);
        repeat (7) @(negedge clk);
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        mode   = 2'd3;
        enable = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
        repeat (200) @(negedge clk);
        enable = 1'b0;
        wait_idle(3000);
        chk("fcnt_after_reset0", int'(g_dut[0].w_fc), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
